// File: rtl/fir_ss_writer.sv
// AXI4-Stream input side of the FIR core: clears the data RAM on start, buffers
// incoming samples in a small FIFO and commits one per core request as a circular buffer.
module fir_ss_writer #(
    parameter int pDATA_WIDTH    = 32,
    parameter int TAP_NUM_WIDTH  = 10,
    parameter int DATA_NUM_WIDTH = 10,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_ap_start,
    input  logic [TAP_NUM_WIDTH-1:0]  in_tap_num,
    input  logic [DATA_NUM_WIDTH-1:0] in_data_num,
    input  logic                      in_ss_tvalid,
    input  logic [pDATA_WIDTH-1:0]    in_ss_tdata,
    input  logic                      in_ss_tlast,
    output logic                      out_ss_tready,
    input  logic                      in_core_data_req,
    output logic                      out_data_EN,
    output logic [pDATA_WIDTH/8-1:0]  out_data_WE,
    output logic [TAP_NUM_WIDTH-1:0]  out_data_A,
    output logic [pDATA_WIDTH-1:0]    out_data_Di,
    output logic [TAP_NUM_WIDTH-1:0]  out_head_ptr,
    output logic                      out_sample_written,
    output logic                      out_core_stall,
    output logic                      out_clr_wait,
    output logic                      out_wr_done,
    output logic                      out_tlast_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CLR, RUN} state_t;
    state_t state;

    logic [TAP_NUM_WIDTH-1:0]  tap_l, clr_cnt, wr_ptr, ptr_next;
    logic [DATA_NUM_WIDTH-1:0] dnum_l, acc_cnt, cmt_cnt, cnt_after;
    logic                      pending;
    logic [pDATA_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]             rd_idx, wr_idx;
    logic [PW:0]               fcnt;
    logic active, fifo_full, fifo_empty, push, pop, serve, direct, req_acc, last_beat, clr_more;

    // A request seen while another is being served becomes the new pending one,
    // since the FIFO can only pop once per cycle.
    always_comb begin
        active        = (state == CLR) || (state == RUN);
        fifo_full     = (fcnt == DEPTH_C);
        fifo_empty    = (fcnt == '0);
        out_ss_tready = active && !fifo_full && (acc_cnt < dnum_l);
        push          = in_ss_tvalid && out_ss_tready;
        last_beat     = (acc_cnt == dnum_l - 1'b1);
        serve         = (state == RUN) && pending && !fifo_empty;
        cnt_after     = cmt_cnt + DATA_NUM_WIDTH'(serve);
        req_acc       = in_core_data_req && (state == RUN) && (!pending || serve)
                        && (cnt_after < dnum_l);
        direct        = req_acc && !serve && !fifo_empty;
        pop           = serve || direct;
        clr_more      = ({1'b0, clr_cnt} + 1'b1) < {1'b0, tap_l};
        ptr_next      = (tap_l == '0 || wr_ptr == tap_l - 1'b1) ? '0 : wr_ptr + 1'b1;
        out_core_stall = pending;
        out_clr_wait   = (state == CLR);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx] <= in_ss_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            tap_l              <= '0;
            dnum_l             <= '0;
            clr_cnt            <= '0;
            acc_cnt            <= '0;
            cmt_cnt            <= '0;
            wr_ptr             <= '0;
            pending            <= 1'b0;
            rd_idx             <= '0;
            wr_idx             <= '0;
            fcnt               <= '0;
            out_data_EN        <= 1'b0;
            out_data_WE        <= '0;
            out_data_A         <= '0;
            out_data_Di        <= '0;
            out_head_ptr       <= '0;
            out_sample_written <= 1'b0;
            out_wr_done        <= 1'b0;
            out_tlast_err      <= 1'b0;
        end else begin
            out_data_EN        <= 1'b0;
            out_data_WE        <= '0;
            out_sample_written <= 1'b0;
            out_wr_done        <= 1'b0;

            if (push) begin
                wr_idx  <= wr_idx + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
                if (in_ss_tlast != last_beat) out_tlast_err <= 1'b1;
            end
            fcnt <= fcnt + (PW+1)'(push) - (PW+1)'(pop);

            if (pop) begin
                rd_idx             <= rd_idx + 1'b1;
                cmt_cnt            <= cmt_cnt + 1'b1;
                out_data_EN        <= 1'b1;
                out_data_WE        <= '1;
                out_data_A         <= wr_ptr;
                out_data_Di        <= fifo_mem[rd_idx];
                out_head_ptr       <= wr_ptr;
                out_sample_written <= 1'b1;
                wr_ptr             <= ptr_next;
            end

            if (serve) pending <= 1'b0;
            if (req_acc && !direct) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (in_ap_start) begin
                        tap_l         <= in_tap_num;
                        dnum_l        <= in_data_num;
                        out_tlast_err <= 1'b0;
                        clr_cnt       <= '0;
                        acc_cnt       <= '0;
                        cmt_cnt       <= '0;
                        wr_ptr        <= '0;
                        pending       <= 1'b0;
                        rd_idx        <= '0;
                        wr_idx        <= '0;
                        fcnt          <= '0;
                        state         <= CLR;
                        if (in_tap_num != '0) begin
                            out_data_EN <= 1'b1;
                            out_data_WE <= '1;
                            out_data_A  <= '0;
                            out_data_Di <= '0;
                        end
                    end
                end
                CLR: begin
                    if (clr_more) begin
                        clr_cnt     <= clr_cnt + 1'b1;
                        out_data_EN <= 1'b1;
                        out_data_WE <= '1;
                        out_data_A  <= clr_cnt + 1'b1;
                        out_data_Di <= '0;
                    end else if (dnum_l == '0) begin
                        state       <= IDLE;
                        out_wr_done <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cmt_cnt == dnum_l) begin
                        state       <= IDLE;
                        out_wr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_ss_writer.sv
// Randomized bench for fir_ss_writer: queue-based reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_fir_ss_writer;
    localparam int DW = 32, TW = 10, NW = 10, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n, in_ap_start, in_ss_tvalid, in_ss_tlast, in_core_data_req;
    logic [TW-1:0] in_tap_num;
    logic [NW-1:0] in_data_num;
    logic [DW-1:0] in_ss_tdata;
    logic          out_ss_tready, out_data_EN, out_sample_written, out_core_stall;
    logic          out_clr_wait, out_wr_done, out_tlast_err;
    logic [DW/8-1:0] out_data_WE;
    logic [TW-1:0] out_data_A, out_head_ptr;
    logic [DW-1:0] out_data_Di;

    fir_ss_writer #(.pDATA_WIDTH(DW), .TAP_NUM_WIDTH(TW), .DATA_NUM_WIDTH(NW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_ap_start(in_ap_start), .in_tap_num(in_tap_num),
        .in_data_num(in_data_num), .in_ss_tvalid(in_ss_tvalid), .in_ss_tdata(in_ss_tdata),
        .in_ss_tlast(in_ss_tlast), .out_ss_tready(out_ss_tready), .in_core_data_req(in_core_data_req),
        .out_data_EN(out_data_EN), .out_data_WE(out_data_WE), .out_data_A(out_data_A),
        .out_data_Di(out_data_Di), .out_head_ptr(out_head_ptr), .out_sample_written(out_sample_written),
        .out_core_stall(out_core_stall), .out_clr_wait(out_clr_wait), .out_wr_done(out_wr_done),
        .out_tlast_err(out_tlast_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // reference model: phase 0 idle, 1 clearing, 2 running
    int m_phase = 0, m_tap = 0, m_dn = 0, m_acc = 0, m_cmt = 0, m_wptr = 0, m_cleared = 0;
    bit m_pend = 0, m_err = 0, started = 0;
    logic [DW-1:0] q[$];
    bit e_en = 0, e_sw = 0, e_done = 0;
    int e_a = 0, e_head = 0;
    logic [DW-1:0] e_di = '0;

    int wlog_a[$], hlog[$];
    logic [DW-1:0] wlog_d[$];
    int done_cnt = 0, clr_cycles = 0, beats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_tready();
        return (m_phase != 0) && (q.size() < DEPTH) && (m_acc < m_dn);
    endfunction

    task automatic emit(input int a, input logic [DW-1:0] d);
        e_en = 1; e_a = a; e_di = d;
    endtask

    task automatic commit_one();
        logic [DW-1:0] d;
        d = q.pop_front();
        emit(m_wptr, d);
        e_head = m_wptr;
        e_sw = 1;
        m_wptr = (m_tap == 0) ? 0 : (m_wptr + 1) % m_tap;
        m_cmt++;
    endtask

    always @(posedge clk) begin
        bit tr, have, serve;
        started = 1'b1;
        e_en = 0; e_sw = 0; e_done = 0;
        if (!rst_n) begin
            m_phase = 0; m_tap = 0; m_dn = 0; m_acc = 0; m_cmt = 0; m_wptr = 0; m_cleared = 0;
            m_pend = 0; m_err = 0; q.delete(); e_a = 0; e_di = '0; e_head = 0;
        end else begin
            tr = exp_tready();
            have = (q.size() > 0);
            serve = 0;
            case (m_phase)
                0: if (in_ap_start) begin
                    m_tap = int'(in_tap_num); m_dn = int'(in_data_num);
                    m_err = 0; q.delete(); m_acc = 0; m_cmt = 0; m_wptr = 0; m_pend = 0;
                    m_cleared = 0; m_phase = 1;
                    if (m_tap > 0) begin emit(0, '0); m_cleared = 1; end
                end
                1: begin
                    if (m_cleared < m_tap) begin emit(m_cleared, '0); m_cleared++; end
                    else if (m_dn == 0) begin m_phase = 0; e_done = 1; end
                    else m_phase = 2;
                end
                default: begin
                    if (m_cmt == m_dn) begin
                        m_phase = 0; e_done = 1;
                    end else begin
                        serve = m_pend && have;
                        if (serve) begin commit_one(); m_pend = 0; end
                        if (in_core_data_req && !m_pend && m_cmt < m_dn) begin
                            if (!serve && have) commit_one();
                            else m_pend = 1;
                        end
                    end
                end
            endcase
            if (tr && in_ss_tvalid) begin
                if (in_ss_tlast != (m_acc == m_dn - 1)) m_err = 1;
                q.push_back(in_ss_tdata);
                m_acc++;
            end
        end
    end

    always @(negedge clk) if (started) begin
        chk("en", out_data_EN, e_en);
        chk("we", out_data_WE, e_en ? 64'hF : 64'h0);
        if (e_en) begin
            chk("addr", out_data_A, e_a);
            chk("di", out_data_Di, e_di);
        end
        chk("head", out_head_ptr, e_head);
        chk("written", out_sample_written, e_sw);
        chk("stall", out_core_stall, m_pend);
        chk("clr_wait", out_clr_wait, m_phase == 1);
        chk("wr_done", out_wr_done, e_done);
        chk("tlast_err", out_tlast_err, m_err);
        chk("tready", out_ss_tready, exp_tready());
        if (out_data_EN) begin wlog_a.push_back(int'(out_data_A)); wlog_d.push_back(out_data_Di); end
        if (out_sample_written) hlog.push_back(int'(out_head_ptr));
        if (out_wr_done) done_cnt++;
        if (out_clr_wait) clr_cycles++;
        if (in_ss_tvalid && out_ss_tready) beats++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        in_ap_start = 0; in_ss_tvalid = 0; in_ss_tlast = 0; in_core_data_req = 0; in_ss_tdata = '0;
    endtask

    task automatic start_frame(input int tap, input int dn);
        in_tap_num = TW'(tap); in_data_num = NW'(dn); in_ap_start = 1;
        tick();
        in_ap_start = 0;
    endtask

    task automatic rand_inputs(input int pv, input int pr, input int tmode, input bit seq);
        in_ss_tvalid = ($urandom_range(0, 99) < pv);
        in_ss_tdata = seq ? DW'(m_acc + 1) : DW'($urandom());
        case (tmode)
            0: in_ss_tlast = (m_acc == m_dn - 1);
            1: in_ss_tlast = (m_acc == m_dn - 1) ^ ($urandom_range(0, 9) == 0);
            default: in_ss_tlast = (m_acc == 2);
        endcase
        in_core_data_req = ($urandom_range(0, 99) < pr);
        in_ap_start = ($urandom_range(0, 29) == 0);
    endtask

    task automatic drive_until_done(input int pv, input int pr, input int tmode, input bit seq);
        int n = 0;
        while (!out_wr_done && n < 3000) begin
            rand_inputs(pv, pr, tmode, seq);
            tick();
            n++;
        end
        clear_inputs();
        chk("frame_completes", out_wr_done, 1);
    endtask

    initial begin
        int exp_a[8], exp_h[5];
        logic [DW-1:0] exp_d[8];
        exp_a = '{0, 1, 2, 0, 1, 2, 0, 1};
        exp_d = '{0, 0, 0, 1, 2, 3, 4, 5};
        exp_h = '{0, 1, 2, 0, 1};

        clear_inputs();
        in_tap_num = '0; in_data_num = '0;
        rst_n = 0; in_ss_tvalid = 1;
        tick(); tick();
        chk("rst_tready", out_ss_tready, 0);
        chk("rst_en", out_data_EN, 0);
        chk("rst_stall", out_core_stall, 0);
        chk("rst_err", out_tlast_err, 0);
        chk("rst_head", out_head_ptr, 0);
        rst_n = 1; in_ss_tvalid = 0;
        tick();

        // clear of 11 words
        wlog_a.delete(); wlog_d.delete(); clr_cycles = 0;
        start_frame(11, 2);
        drive_until_done(50, 50, 0, 0);
        tick();
        chk("clr_cycles", clr_cycles, 11);
        chk("clr_nwrites", wlog_a.size(), 13);
        for (int i = 0; i < 11 && i < wlog_a.size(); i++) begin
            chk("clr_addr", wlog_a[i], i);
            chk("clr_data", wlog_d[i], 0);
        end

        // circular commit with wrap
        wlog_a.delete(); wlog_d.delete(); hlog.delete(); done_cnt = 0;
        start_frame(3, 5);
        drive_until_done(80, 40, 0, 1);
        tick();
        chk("wrap_nwrites", wlog_a.size(), 8);
        for (int i = 0; i < 8 && i < wlog_a.size(); i++) begin
            chk("wrap_addr", wlog_a[i], exp_a[i]);
            chk("wrap_data", wlog_d[i], exp_d[i]);
        end
        chk("wrap_nheads", hlog.size(), 5);
        for (int i = 0; i < 5 && i < hlog.size(); i++) chk("wrap_head", hlog[i], exp_h[i]);
        chk("wrap_done_cnt", done_cnt, 1);

        // backpressure
        start_frame(2, 8);
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            in_ss_tvalid = 1; in_ss_tdata = DW'($urandom()); in_ss_tlast = (m_acc == m_dn - 1);
            tick();
        end
        chk("bp_beats", beats, 4);
        chk("bp_tready_full", out_ss_tready, 0);
        in_core_data_req = 1;
        tick();
        in_core_data_req = 0;
        chk("bp_tready_back", out_ss_tready, 1);
        drive_until_done(100, 40, 0, 0);
        tick();

        // stall
        start_frame(4, 2);
        for (int i = 0; i < 20 && m_phase != 2; i++) tick();
        in_core_data_req = 1; tick(); in_core_data_req = 0;
        chk("stall_set", out_core_stall, 1);
        tick();
        in_core_data_req = 1; tick(); in_core_data_req = 0;
        in_ss_tvalid = 1; in_ss_tdata = 32'h7; in_ss_tlast = 0;
        tick();
        in_ss_tvalid = 0;
        chk("stall_hold", out_core_stall, 1);
        chk("stall_no_write", out_data_EN, 0);
        tick();
        chk("stall_write_en", out_data_EN, 1);
        chk("stall_write_data", out_data_Di, 32'h7);
        chk("stall_cleared", out_core_stall, 0);
        in_ss_tvalid = 1; in_ss_tdata = 32'h9; in_ss_tlast = 1;
        tick();
        in_ss_tvalid = 0;
        tick(); tick();
        chk("dropped_no_write", out_data_EN, 0);
        chk("dropped_no_stall", out_core_stall, 0);
        in_core_data_req = 1; tick(); in_core_data_req = 0;
        tick();
        chk("second_write_data", out_data_Di, 32'h9);
        drive_until_done(0, 0, 0, 0);
        tick();

        // tlast on the wrong beat
        start_frame(4, 4);
        drive_until_done(70, 40, 2, 0);
        tick();
        chk("tlast_err_sticky", out_tlast_err, 1);
        start_frame(2, 1);
        chk("tlast_err_cleared", out_tlast_err, 0);
        drive_until_done(70, 40, 0, 0);
        tick();

        // randomized frames including zero taps and zero samples
        for (int f = 0; f < 30; f++) begin
            start_frame($urandom_range(0, 6), $urandom_range(0, 12));
            drive_until_done($urandom_range(20, 100), $urandom_range(10, 80), $urandom_range(0, 1), 0);
            for (int i = 0; i < 2; i++) begin
                in_core_data_req = $urandom_range(0, 1); in_ss_tvalid = $urandom_range(0, 1);
                tick();
            end
            clear_inputs();
        end

        // reset in the middle of a frame
        start_frame(5, 10);
        for (int i = 0; i < 12; i++) begin rand_inputs(60, 30, 0, 0); in_ap_start = 0; tick(); end
        clear_inputs();
        rst_n = 0; in_ss_tvalid = 1;
        tick(); tick();
        chk("midrst_tready", out_ss_tready, 0);
        chk("midrst_clr", out_clr_wait, 0);
        chk("midrst_stall", out_core_stall, 0);
        rst_n = 1; in_ss_tvalid = 0;
        tick();
        start_frame(3, 6);
        drive_until_done(60, 50, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
